// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_pkg
//   Shared types and constants for the mux scan sequencer.
//   - state_t           : sequencer FSM state (IDLE, SETTLE, DONE)
//   - NUM_CH, SEL_W     : channel count and select width of the 4:1 selector
//   - LAST_CH           : highest channel index
//   - has_enabled_from  : any channel >= from enabled in a mask
//   - first_enabled_from: lowest enabled channel index >= from
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  function automatic logic has_enabled_from(input logic [NUM_CH-1:0] mask, input int from);
    logic found;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k >= from && mask[k]) found = 1'b1;
    end
    return found;
  endfunction

  // Scanning downwards leaves the lowest qualifying index as the result.
  function automatic logic [SEL_W-1:0] first_enabled_from(input logic [NUM_CH-1:0] mask, input int from);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (k >= from && mask[k]) res = SEL_W'(k);
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// dwell_counter
//   Counts settle cycles on the current channel and flags the edge on which
//   the count has reached the programmed limit.
//   Ports:
//     i_clk    : clock, rising edge
//     i_rst_n  : asynchronous active-low reset
//     i_clr    : synchronous clear to 0 (takes priority over i_en)
//     i_en     : count enable; the count self-clears on a hit
//     i_limit  : dwell limit, compared against the current count
//     o_hit    : count equals limit (the capture edge when enabled)
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_limit,
  output logic               o_hit
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign o_hit = (cnt_q == i_limit);

  // Resetting on the hit means the count never exceeds the limit, so it
  // cannot wrap even with the limit at its maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      if (o_hit) cnt_d = '0;
      else       cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Drives the select of a 4:1 data selector, waits a programmable settle
//   time on each channel, and captures the selected word into a per-channel
//   register. One i_start runs one full scan; o_done pulses when complete.
//   Optional feature macro: MUX_SCAN_MASK_EN (adds i_mask channel enables).
//   Ports:
//     i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//     i_start        : scan request, sampled only in IDLE
//     i_dwell        : extra settle cycles per channel, sampled with i_start
//     i_mask         : (MUX_SCAN_MASK_EN only) channel enables, sampled with i_start
//     i_mux_dato     : selected word from the selector
//     o_sel          : channel select to the selector
//     o_dato_0..3    : captured word per channel
//     o_valido       : bit k set when channel k was captured in this scan
//     o_busy         : high while settling/capturing
//     o_done         : one-cycle completion pulse
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int n       = 4,
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [DWELL_W-1:0] i_dwell,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NUM_CH-1:0]  i_mask,
`endif
  input  logic [n-1:0]       i_mux_dato,
  output logic [SEL_W-1:0]   o_sel,
  output logic [n-1:0]       o_dato_0,
  output logic [n-1:0]       o_dato_1,
  output logic [n-1:0]       o_dato_2,
  output logic [n-1:0]       o_dato_3,
  output logic [NUM_CH-1:0]  o_valido,
  output logic               o_busy,
  output logic               o_done
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NUM_CH-1:0]  valido_q, valido_d;
  logic [n-1:0]       dato_q [NUM_CH];
  logic [n-1:0]       dato_d [NUM_CH];
  logic               cnt_clr, cnt_en, cnt_hit;

  // mask_in is the live enable set seen in IDLE; mask_q is the set frozen
  // for the running scan. Without the mask feature every channel is enabled.
  logic [NUM_CH-1:0]  mask_in, mask_q;

`ifdef MUX_SCAN_MASK_EN
  logic [NUM_CH-1:0]  mask_d;

  assign mask_in = i_mask;

  always_comb begin
    mask_d = mask_q;
    if (state_q == IDLE && i_start) mask_d = i_mask;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mask_q <= '0;
    else          mask_q <= mask_d;
  end
`else
  assign mask_in = '1;
  assign mask_q  = '1;
`endif

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .i_limit (dwell_q),
    .o_hit   (cnt_hit)
  );

  // Next-state and datapath. A scan starts at the lowest enabled channel;
  // each capture either advances to the next enabled channel or, on the last
  // one, finishes the scan. With no channel enabled the scan goes straight
  // to DONE.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dwell_d  = dwell_q;
    valido_d = valido_q;
    dato_d   = dato_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (i_start) begin
          dwell_d  = i_dwell;
          valido_d = '0;
          cnt_clr  = 1'b1;
          if (has_enabled_from(mask_in, 0)) begin
            sel_d   = first_enabled_from(mask_in, 0);
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_hit) begin
          dato_d[sel_q]   = i_mux_dato;
          valido_d[sel_q] = 1'b1;
          if (has_enabled_from(mask_q, int'(sel_q) + 1)) begin
            sel_d = first_enabled_from(mask_q, int'(sel_q) + 1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      dwell_q  <= '0;
      valido_q <= '0;
      for (int k = 0; k < NUM_CH; k++) dato_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      dwell_q  <= dwell_d;
      valido_q <= valido_d;
      dato_q   <= dato_d;
    end
  end

  assign o_sel    = sel_q;
  assign o_valido = valido_q;
  assign o_dato_0 = dato_q[0];
  assign o_dato_1 = dato_q[1];
  assign o_dato_2 = dato_q[2];
  assign o_dato_3 = dato_q[3];
  assign o_busy   = (state_q == SETTLE);
  assign o_done   = (state_q == DONE);

  // A reset mid-scan simply returns everything to IDLE; nothing to resume.

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [DW-1:0] i_dwell;
  logic [N-1:0]  mux_dato;
  logic [1:0]    sel;
  logic [N-1:0]  dato_0, dato_1, dato_2, dato_3;
  logic [3:0]    valido;
  logic          busy, done;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0]    mask;
`endif

  // Selector inputs (i_Datos_0..3) and a behavioural 4:1 selector
  logic [N-1:0]  datos [4];
  logic [N-1:0]  dato_out [4];
  logic [N-1:0]  model_data [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mux_dato = datos[sel];
  assign dato_out[0] = dato_0;
  assign dato_out[1] = dato_1;
  assign dato_out[2] = dato_2;
  assign dato_out[3] = dato_3;

  mux_scan_sequencer #(.n(N), .DWELL_W(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_dwell    (i_dwell),
`ifdef MUX_SCAN_MASK_EN
    .i_mask     (mask),
`endif
    .i_mux_dato (mux_dato),
    .o_sel      (sel),
    .o_dato_0   (dato_0),
    .o_dato_1   (dato_1),
    .o_dato_2   (dato_2),
    .o_dato_3   (dato_3),
    .o_valido   (valido),
    .o_busy     (busy),
    .o_done     (done)
  );

  typedef struct {
    int           dwell;
    logic [N-1:0] d [4];
    int           latency;
  } vec_t;

  vec_t tbl [4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [DW-1:0] dwell);
    i_start = start;
    i_dwell = dwell;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then checks every cycle against the arithmetic model:
  // after edge E0+j the scan is on channel j/(D+1) with j/(D+1) channels
  // captured; DONE follows 4*(D+1) edges after E0. Word k is the selector
  // value present just before its capture edge. A stray start pulse in the
  // middle of the scan must be ignored.
  task automatic run_scan(input int d, input int lat, input int chg_j, input logic [N-1:0] chg_val);
    int cap;
    applyStimulus(1'b1, DW'(d));
    step();
    applyStimulus(1'b0, DW'($urandom_range(0, 15)));
    for (int j = 0; j <= lat; j++) begin
      cap = (j < lat) ? j / (d + 1) : 4;
      if (j < lat) begin
        checkOutput("scan_sel",  32'(sel),  32'(j / (d + 1)));
        checkOutput("scan_busy", 32'(busy), 32'd1);
        checkOutput("scan_done", 32'(done), 32'd0);
      end else begin
        checkOutput("done_sel",  32'(sel),  32'd3);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_pulse", 32'(done), 32'd1);
      end
      checkOutput("scan_valido", 32'(valido), 32'((1 << cap) - 1));
      if (j == chg_j) datos[2] = chg_val;
      if (j == lat / 2)     i_start = 1'b1;
      if (j == lat / 2 + 1) i_start = 1'b0;
      if (j < lat) begin
        if ((j + 1) % (d + 1) == 0) model_data[(j + 1) / (d + 1) - 1] = datos[(j + 1) / (d + 1) - 1];
        step();
      end
    end
    for (int k = 0; k < 4; k++) checkOutput($sformatf("dato_%0d", k), 32'(dato_out[k]), 32'(model_data[k]));
    step();
    checkOutput("idle_sel",  32'(sel),  32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    tbl[0] = '{dwell: 0,  d: '{4'h1, 4'h2, 4'h3, 4'h4}, latency: 4};
    tbl[1] = '{dwell: 3,  d: '{4'h1, 4'h2, 4'h3, 4'h4}, latency: 16};
    tbl[2] = '{dwell: 1,  d: '{4'hA, 4'h5, 4'hF, 4'h0}, latency: 8};
    tbl[3] = '{dwell: 15, d: '{4'h7, 4'h8, 4'h9, 4'h6}, latency: 64};

    for (int k = 0; k < 4; k++) begin
      datos[k]      = N'(k + 1);
      model_data[k] = '0;
    end
`ifdef MUX_SCAN_MASK_EN
    mask = 4'hF;
`endif
    applyStimulus(1'b0, '0);
    rst_n = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_sel",    32'(sel),    32'd0);
    checkOutput("rst_busy",   32'(busy),   32'd0);
    checkOutput("rst_done",   32'(done),   32'd0);
    checkOutput("rst_valido", 32'(valido), 32'd0);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("rst_dato_%0d", k), 32'(dato_out[k]), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // Table-driven scans
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) datos[k] = tbl[t].d[k];
      $display("[TB] table scan %0d dwell=%0d", t, tbl[t].dwell);
      run_scan(tbl[t].dwell, tbl[t].latency, -1, '0);
    end

    // Selector input for channel 2 changes during its dwell
    for (int k = 0; k < 4; k++) datos[k] = N'(k + 1);
    run_scan(3, 16, 9, 4'h9);
    checkOutput("late_change_dato_2", 32'(dato_2), 32'h9);

    // Start held high with a mid-scan dwell change: back-to-back scans,
    // one IDLE cycle between, second scan uses the new dwell.
    applyStimulus(1'b1, 4'd2);
    step();
    for (int j = 0; j <= 40; j++) begin
      if (j < 12) begin
        checkOutput("hold_sel1",  32'(sel),  32'(j / 3));
        checkOutput("hold_busy1", 32'(busy), 32'd1);
      end else if (j == 12 || j == 38) begin
        checkOutput("hold_done", 32'(done), 32'd1);
        checkOutput("hold_busy", 32'(busy), 32'd0);
      end else if (j == 13 || j >= 39) begin
        checkOutput("hold_idle_busy", 32'(busy), 32'd0);
        checkOutput("hold_idle_sel",  32'(sel),  32'd0);
        checkOutput("hold_idle_done", 32'(done), 32'd0);
      end else begin
        checkOutput("hold_sel2",  32'(sel),  32'((j - 14) / 6));
        checkOutput("hold_busy2", 32'(busy), 32'd1);
      end
      if (j == 3)  i_dwell = 4'd5;
      if (j == 39) i_start = 1'b0;
      if (j < 40) step();
    end

    // Reset at E6 of a dwell=3 scan
    for (int k = 0; k < 4; k++) datos[k] = N'(k + 1);
    applyStimulus(1'b1, 4'd3);
    step();
    applyStimulus(1'b0, 4'd3);
    repeat (6) step();
    checkOutput("pre_rst_valido", 32'(valido), 32'd1);
    checkOutput("pre_rst_dato_0", 32'(dato_0), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sel",    32'(sel),    32'd0);
    checkOutput("async_rst_busy",   32'(busy),   32'd0);
    checkOutput("async_rst_valido", 32'(valido), 32'd0);
    checkOutput("async_rst_dato_0", 32'(dato_0), 32'd0);
    #3 rst_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) model_data[k] = '0;
    run_scan(2, 12, -1, '0);

    // Randomized scans against the model
    for (int r = 0; r < 10; r++) begin
      int d;
      d = $urandom_range(0, 7);
      for (int k = 0; k < 4; k++) datos[k] = N'($urandom);
      run_scan(d, 4 * (d + 1), -1, '0);
    end

`ifdef MUX_SCAN_MASK_EN
    // Mask 1010, dwell 0: channels 1 and 3 only
    for (int k = 0; k < 4; k++) datos[k] = N'(k + 1);
    mask = 4'b1010;
    applyStimulus(1'b1, 4'd0);
    step();
    applyStimulus(1'b0, 4'd0);
    checkOutput("mask_sel_first", 32'(sel),    32'd1);
    checkOutput("mask_valido0",   32'(valido), 32'd0);
    step();
    checkOutput("mask_sel_next",  32'(sel),    32'd3);
    checkOutput("mask_valido1",   32'(valido), 32'b0010);
    step();
    checkOutput("mask_done",      32'(done),   32'd1);
    checkOutput("mask_valido2",   32'(valido), 32'b1010);
    checkOutput("mask_dato_1",    32'(dato_1), 32'd2);
    checkOutput("mask_dato_3",    32'(dato_3), 32'd4);
    checkOutput("mask_dato_0",    32'(dato_0), 32'(model_data[0]));
    checkOutput("mask_dato_2",    32'(dato_2), 32'(model_data[2]));
    step();
    checkOutput("mask_idle_done", 32'(done),   32'd0);

    // Empty mask: straight to DONE
    mask = 4'b0000;
    applyStimulus(1'b1, 4'd5);
    step();
    applyStimulus(1'b0, 4'd0);
    checkOutput("mask0_done",   32'(done),   32'd1);
    checkOutput("mask0_busy",   32'(busy),   32'd0);
    checkOutput("mask0_valido", 32'(valido), 32'd0);
    step();
    checkOutput("mask0_after",  32'(done),   32'd0);
    mask = 4'hF;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
